excess3_word_collector: RTL

- Downstream of the serial-to-excess-3 stage. Consumes its 4-bit excess-3 code stream (one code per 4-clock frame, 0000 between frames).
- Decodes each code back to BCD and range-checks it. Assembles NDIGITS consecutive digits into one packed BCD word for the display/time-set logic.
- Flags bad codes and stalled partial words.

---
 rtl/excess3_word_collector_pkg.sv | 19 +
 rtl/excess3_decode.sv | 16 +
 rtl/excess3_word_collector.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/excess3_word_collector_pkg.sv
// Shared constants, FSM state encoding and code-validity helper for the
// excess-3 word collector and any other excess-3 consumer.
package excess3_word_collector_pkg;

    localparam logic [3:0] EX3_OFFSET = 4'd3;
    localparam logic [3:0] EX3_MIN    = 4'd3;
    localparam logic [3:0] EX3_MAX    = 4'd12;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    // A code is a legal decimal digit only inside the 3..12 window.
    function automatic logic ex3_is_valid(input logic [3:0] code);
        return (code >= EX3_MIN) && (code <= EX3_MAX);
    endfunction

endpackage

// File: rtl/excess3_decode.sv
// Combinational excess-3 decoder: strobe on any non-zero code, range check,
// and the mod-16 digit value (meaningful only when valid_o is high).
module excess3_decode
    import excess3_word_collector_pkg::*;
(
    input  logic [3:0] z_i,
    output logic       strobe_o,
    output logic       valid_o,
    output logic [3:0] d_o
);

    assign strobe_o = (z_i != 4'd0);
    assign valid_o  = strobe_o && ex3_is_valid(z_i);
    assign d_o      = z_i - EX3_OFFSET;

endmodule

// File: rtl/excess3_word_collector.sv
// Assembles NDIGITS excess-3 codes into one packed BCD word, flagging bad
// codes and partial words that stall for TIMEOUT cycles.
module excess3_word_collector
    import excess3_word_collector_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [3:0]                       z,
    output logic [4*NDIGITS-1:0]             bcd_out,
    output logic                             word_valid,
    output logic                             digit_err,
    output logic                             timeout_err,
    output logic [$clog2(NDIGITS+1)-1:0]     digit_cnt
);

    localparam int WW = 4 * NDIGITS;
    localparam int CW = $clog2(NDIGITS + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_FULL   = CW'(NDIGITS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [WW-1:0]   shift_q, shift_d;
    logic [WW-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            wv_q, wv_d;
    logic            de_q, de_d;
    logic            to_q, to_d;

    logic            dec_strobe;
    logic            dec_valid;
    logic [3:0]      dec_d;
    logic [CW-1:0]   cnt_inc;
    logic [WW-1:0]   shift_in;

    excess3_decode u_decode (
        .z_i      (z),
        .strobe_o (dec_strobe),
        .valid_o  (dec_valid),
        .d_o      (dec_d)
    );

    assign cnt_inc  = cnt_q + CW'(1);
    assign shift_in = {shift_q[WW-5:0], dec_d};

    // Next-state logic: digit accumulation, error detection and inactivity timer.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        wv_d    = 1'b0;
        de_d    = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (dec_strobe && dec_valid) begin
                    shift_d = {{(WW-4){1'b0}}, dec_d};
                    cnt_d   = CW'(1);
                    state_d = COLLECT;
                end else if (dec_strobe) begin
                    de_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                // A code arriving on the expiry cycle wins over the timeout.
                if (dec_strobe && dec_valid) begin
                    timer_d = '0;
                    if (cnt_inc == CNT_FULL) begin
                        bcd_d   = shift_in;
                        wv_d    = 1'b1;
                        shift_d = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        shift_d = shift_in;
                        cnt_d   = cnt_inc;
                    end
                end else if (dec_strobe) begin
                    de_d    = 1'b1;
                    shift_d = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    to_d    = 1'b1;
                    shift_d = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                shift_d = '0;
                cnt_d   = '0;
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            wv_q    <= 1'b0;
            de_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            wv_q    <= wv_d;
            de_q    <= de_d;
            to_q    <= to_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign word_valid  = wv_q;
    assign digit_err   = de_q;
    assign timeout_err = to_q;
    assign digit_cnt   = cnt_q;

endmodule
